// File: rtl/crank_pulse_gen.sv
// crank_pulse_gen
//   Synthetic crank-speed and reference-mark source. Produces a train of
//   speed-tooth pulses (ign) whose period is floor(RPM_CONST/rpm) clocks,
//   plus a reference-mark pulse (trigger) once per revolution of TEETH teeth.
//   The tooth period comes from a 32-cycle restoring serial divider.
//
// Optional feature (macro RPM_RAMP_EN):
//   When defined, a background division computes the period for the next
//   revolution's rpm (rpm_now + RPM_STEP, clamped to RPM_END). Both are
//   swapped in at the last-tooth wrap, so rpm ramps once per revolution.
//   When undefined, rpm_now stays at RPM_START and the divider runs only
//   when leaving IDLE.
//
// Ports
//   clk         in   1   bench clock
//   rst         in   1   asynchronous reset, active high
//   run         in   1   level enable; low forces IDLE on the next clock
//   ign         out  1   speed tooth pulse train (high PULSE_W clocks per tooth)
//   trigger     out  1   reference-mark pulse, tooth 0 only, TRIG_W clocks
//   rpm_now     out  14  rpm currently in effect
//   period_now  out  24  tooth period in clocks currently in effect
//   busy        out  1   high in DIV or COUNT
//
// Handshake: there is no valid/ready pair here; run is a plain level
// enable sampled on every rising clk edge, and all outputs are registered.
module crank_pulse_gen #(
  parameter logic [13:0] RPM_START = 14'd840,
  parameter logic [13:0] RPM_END   = 14'd6500,
  parameter logic [13:0] RPM_STEP  = 14'd20,
  parameter logic [31:0] RPM_CONST = 32'd2728000,
  parameter int          TEETH     = 130,
  parameter int          PULSE_W   = 8,
  parameter int          TRIG_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        ign,
  output logic        trigger,
  output logic [13:0] rpm_now,
  output logic [23:0] period_now,
  output logic        busy
);

`ifdef RPM_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  localparam int TW = (TEETH > 1) ? $clog2(TEETH) : 1;
  localparam logic [TW-1:0] TOOTH_LAST = TW'(TEETH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    COUNT = 2'd2
  } state_t;

  // FSM state; a plain named register so checkers can bind to it.
  state_t state;

  logic [23:0]   cnt;
  logic [TW-1:0] tooth;

  // Serial divider datapath (shared by the IDLE start and background runs).
  logic        dv_run;
  logic [4:0]  dv_cnt;
  logic [13:0] dv_rem;
  logic [31:0] dv_quo;      // dividend shifts out the top, quotient in the bottom
  logic [13:0] dv_divisor;

  // Next-revolution values; only loaded when the ramp feature is built in.
  logic [13:0] rpm_next;
  logic [23:0] period_next;

  logic [14:0] dv_rem_sh;
  logic        dv_ge;
  logic [13:0] dv_rem_nxt;
  logic [31:0] dv_quo_nxt;
  logic        dv_last;
  logic [23:0] dv_result;
  logic [14:0] rpm_sum;
  logic [13:0] rpm_target;

  always_comb begin
    dv_rem_sh  = {dv_rem, dv_quo[31]};
    dv_ge      = (dv_rem_sh >= {1'b0, dv_divisor});
    // Remainder stays below the divisor, so the 14-bit truncation is exact.
    dv_rem_nxt = dv_ge ? 14'(dv_rem_sh - {1'b0, dv_divisor}) : dv_rem_sh[13:0];
    dv_quo_nxt = {dv_quo[30:0], dv_ge};
    dv_last    = dv_run && (dv_cnt == 5'd31);
    // Saturate quotients that do not fit 24 bits; a zero divisor saturates too.
    if ((dv_divisor == 14'd0) || (|dv_quo_nxt[31:24]))
      dv_result = 24'hFFFFFF;
    else
      dv_result = dv_quo_nxt[23:0];
    // 15-bit sum so a large step cannot wrap before the ceiling clamp.
    rpm_sum    = {1'b0, rpm_now} + {1'b0, RPM_STEP};
    rpm_target = (rpm_sum > {1'b0, RPM_END}) ? RPM_END : rpm_sum[13:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ign         <= 1'b0;
      trigger     <= 1'b0;
      busy        <= 1'b0;
      rpm_now     <= RPM_START;
      period_now  <= 24'd0;
      cnt         <= 24'd0;
      tooth       <= '0;
      dv_run      <= 1'b0;
      dv_cnt      <= 5'd0;
      dv_rem      <= 14'd0;
      dv_quo      <= 32'd0;
      dv_divisor  <= 14'd0;
      rpm_next    <= RPM_START;
      period_next <= 24'd0;
    end else if (!run) begin
      // Abort everything but keep rpm_now/period_now for the next start.
      state   <= IDLE;
      ign     <= 1'b0;
      trigger <= 1'b0;
      busy    <= 1'b0;
      cnt     <= 24'd0;
      tooth   <= '0;
      dv_run  <= 1'b0;
    end else begin
      if (dv_run) begin
        dv_rem <= dv_rem_nxt;
        dv_quo <= dv_quo_nxt;
        dv_cnt <= dv_cnt + 5'd1;
        if (dv_last) dv_run <= 1'b0;
      end

      case (state)
        IDLE: begin
          dv_run     <= 1'b1;
          dv_cnt     <= 5'd0;
          dv_rem     <= 14'd0;
          dv_quo     <= RPM_CONST;
          dv_divisor <= rpm_now;
          busy       <= 1'b1;
          state      <= DIV;
        end

        DIV: begin
          if (dv_last) begin
            period_now <= dv_result;
            cnt        <= 24'd0;
            tooth      <= '0;
            state      <= COUNT;
          end
        end

        COUNT: begin
          ign     <= (cnt < 24'(PULSE_W));
          trigger <= (tooth == '0) && (cnt < 24'(TRIG_W));

          if (cnt >= period_now - 24'd1) begin
            cnt <= 24'd0;
            if (tooth == TOOTH_LAST) begin
              tooth <= '0;
              if (RAMP_EN) begin
                rpm_now    <= rpm_next;
                period_now <= period_next;
              end
            end else begin
              tooth <= tooth + TW'(1);
            end
          end else begin
            cnt <= cnt + 24'd1;
          end

          if (RAMP_EN) begin
            if (dv_last) period_next <= dv_result;
            // Kick the background division at the start of each revolution.
            if ((tooth == '0) && (cnt == 24'd0)) begin
              rpm_next   <= rpm_target;
              dv_run     <= 1'b1;
              dv_cnt     <= 5'd0;
              dv_rem     <= 14'd0;
              dv_quo     <= RPM_CONST;
              dv_divisor <= rpm_target;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crank_pulse_gen.sv
module tb_crank_pulse_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: all defaults.
  logic        rst_a, run_a, ign_a, trig_a, busy_a;
  logic [13:0] rpm_a;
  logic [23:0] per_a;

  // Instance B: short revolution, period 64.
  logic        rst_b, run_b, ign_b, trig_b, busy_b;
  logic [13:0] rpm_b;
  logic [23:0] per_b;

  // Instance C: ramp parameters (ramps only when RPM_RAMP_EN is defined).
  logic        rst_c, run_c, ign_c, trig_c, busy_c;
  logic [13:0] rpm_c;
  logic [23:0] per_c;

  crank_pulse_gen u_def (
    .clk(clk), .rst(rst_a), .run(run_a), .ign(ign_a), .trigger(trig_a),
    .rpm_now(rpm_a), .period_now(per_a), .busy(busy_a)
  );

  crank_pulse_gen #(
    .RPM_START(14'd100), .RPM_END(14'd100), .RPM_CONST(32'd6400), .TEETH(4)
  ) u_small (
    .clk(clk), .rst(rst_b), .run(run_b), .ign(ign_b), .trigger(trig_b),
    .rpm_now(rpm_b), .period_now(per_b), .busy(busy_b)
  );

  crank_pulse_gen #(
    .RPM_START(14'd840), .RPM_END(14'd1000), .RPM_STEP(14'd100), .TEETH(4)
  ) u_ramp (
    .clk(clk), .rst(rst_c), .run(run_c), .ign(ign_c), .trigger(trig_c),
    .rpm_now(rpm_c), .period_now(per_c), .busy(busy_c)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int rpm_exp [3];
  int per_exp [3];
  int prev_per;

  initial begin
`ifdef RPM_RAMP_EN
    rpm_exp = '{940, 1000, 1000};
    per_exp = '{2902, 2728, 2728};
`else
    rpm_exp = '{840, 840, 840};
    per_exp = '{3247, 3247, 3247};
`endif
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    run_a = 1'b0; run_b = 1'b0; run_c = 1'b0;
    tick(3);

    // Reset values
    check("rst_ign",     32'(ign_a),  32'd0);
    check("rst_trigger", 32'(trig_a), 32'd0);
    check("rst_busy",    32'(busy_a), 32'd0);
    check("rst_rpm",     32'(rpm_a),  32'd840);
    check("rst_period",  32'(per_a),  32'd0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick(2);

    // T1: start timing, first tooth, tooth spacing
    run_a = 1'b1;
    tick(1);                                   // t0 samples run=1
    check("t1_busy_t0", 32'(busy_a), 32'd1);
    check("t1_ign_t0",  32'(ign_a),  32'd0);
    tick(32);                                  // t0+32: divider done
    check("t1_ign_t32",    32'(ign_a), 32'd0);
    check("t1_period_t32", 32'(per_a), 32'd3247);
    tick(1);                                   // t0+33: first rise
    check("t1_ign_rise", 32'(ign_a),  32'd1);
    check("t1_trig_rev", 32'(trig_a), 32'd1);
    tick(7);                                   // 8th high clock
    check("t1_ign_hi8", 32'(ign_a), 32'd1);
    tick(1);
    check("t1_ign_fall", 32'(ign_a),  32'd0);
    check("t1_trig_fall", 32'(trig_a), 32'd0);
    tick(3238);                                // t0+3279
    check("t1_ign_pre2", 32'(ign_a), 32'd0);
    tick(1);                                   // t0+3280: second rise
    check("t1_ign_rise2",  32'(ign_a),  32'd1);
    check("t1_trig_tooth1", 32'(trig_a), 32'd0);

    // T6 (defaults, short span): values remain fixed across teeth
    tick(2 * 3247);
    check("t6_ign_rise4", 32'(ign_a), 32'd1);
    check("t6_rpm_def",   32'(rpm_a), 32'd840);
    check("t6_per_def",   32'(per_a), 32'd3247);

    // T4: drop run while ign is high
    run_a = 1'b0;
    tick(1);
    check("t4_ign",     32'(ign_a),  32'd0);
    check("t4_busy",    32'(busy_a), 32'd0);
    check("t4_trigger", 32'(trig_a), 32'd0);
    check("t4_rpm",     32'(rpm_a),  32'd840);
    check("t4_period",  32'(per_a),  32'd3247);
    run_a = 1'b1;
    tick(1);
    check("t4_busy_restart", 32'(busy_a), 32'd1);
    tick(32);
    check("t4_ign_t32", 32'(ign_a), 32'd0);
    tick(1);
    check("t4_ign_t33", 32'(ign_a), 32'd1);

    // T5: reset pulsed 10 clocks into DIV, checked with no clock edge
    run_a = 1'b0;
    tick(1);
    run_a = 1'b1;
    tick(1);
    tick(10);
    check("t5_busy_div", 32'(busy_a), 32'd1);
    rst_a = 1'b1;
    #1;
    check("t5_ign",     32'(ign_a),  32'd0);
    check("t5_trigger", 32'(trig_a), 32'd0);
    check("t5_busy",    32'(busy_a), 32'd0);
    check("t5_rpm",     32'(rpm_a),  32'd840);
    check("t5_period",  32'(per_a),  32'd0);
    run_a = 1'b0;
    tick(1);
    rst_a = 1'b0;

    // T2 + T6: period 64, trigger every 4th tooth, 10 revolutions
    run_b = 1'b1;
    tick(1);
    tick(32);
    check("t2_period", 32'(per_b), 32'd64);
    check("t2_ign_t32", 32'(ign_b), 32'd0);
    for (int k = 0; k < 2560; k++) begin
      tick(1);
      check("t2_ign",     32'(ign_b),  ((k % 64) < 8) ? 32'd1 : 32'd0);
      check("t2_trigger", 32'(trig_b), ((k % 256) < 8) ? 32'd1 : 32'd0);
      if ((k % 256) == 255) begin
        check("t6_rpm",    32'(rpm_b), 32'd100);
        check("t6_period", 32'(per_b), 32'd64);
      end
    end
    run_b = 1'b0;

    // T3: per-revolution values at each last-tooth wrap
    run_c = 1'b1;
    tick(1);
    tick(32);
    check("t3_rpm0", 32'(rpm_c), 32'd840);
    check("t3_per0", 32'(per_c), 32'd3247);
    prev_per = 3247;
    tick(4 * prev_per - 1);
    check("t3_rpm_prewrap", 32'(rpm_c), 32'd840);
    tick(1);
    for (int r = 0; r < 3; r++) begin
      check("t3_rpm_rev", 32'(rpm_c), 32'(rpm_exp[r]));
      check("t3_per_rev", 32'(per_c), 32'(per_exp[r]));
      tick(1);
      check("t3_ign_nogap",  32'(ign_c),  32'd1);
      check("t3_trig_nogap", 32'(trig_c), 32'd1);
      if (r < 2) begin
        prev_per = per_exp[r];
        tick(4 * prev_per - 1);
      end
    end
    run_c = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
